calculate_4_0_key_loader: RTL and testbench

Upstream key-provisioning stage for the locked `calculate_4_0_obf` datapath. It receives the 255-bit locking key serially from the key store, followed by an 8-bit CRC. It verifies the CRC and only then presents the key in parallel on `locking_key`. It also gates `ap_start` so the locked block is never started with an unverified key.

---
 rtl/calc_lock_pkg.sv | 26 ++
 rtl/crc8_serial.sv | 35 +++
 rtl/calculate_4_0_key_loader.sv | 109 ++++++++++
 tb/tb_calculate_4_0_key_loader.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/calc_lock_pkg.sv
// rtl/calc_lock_pkg.sv - shared constants, state type and CRC-8 step for the locked datapath key path
package calc_lock_pkg;

   localparam int KEY_W = 255;
   localparam int CRC_W = 8;
   localparam int CNT_W = 9;
   localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;
   localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_W - 1);
   localparam logic [CNT_W-1:0] CRC_LAST = CNT_W'(CRC_W - 1);

   typedef enum logic [2:0] {
      IDLE,
      SHIFT_KEY,
      SHIFT_CRC,
      LOCKED,
      ERROR
   } key_ld_state_t;

   // MSB-first CRC-8, no reflection: one message bit per call.
   function automatic logic [CRC_W-1:0] crc8_step(input logic [CRC_W-1:0] crc, input logic din);
      logic fb;
      fb = crc[CRC_W-1] ^ din;
      return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
   endfunction

endpackage

// File: rtl/crc8_serial.sv
// rtl/crc8_serial.sv - bit-serial CRC-8 accumulator with synchronous clear
module crc8_serial
   import calc_lock_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic             bit_i,
   output logic [CRC_W-1:0] crc_o
);

   logic [CRC_W-1:0] crc_q;
   logic [CRC_W-1:0] crc_d;

   always_comb begin
      crc_d = crc_q;
      if (clr_i) begin
         crc_d = '0;
      end else if (en_i) begin
         crc_d = crc8_step(crc_q, bit_i);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         crc_q <= '0;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/calculate_4_0_key_loader.sv
// rtl/calculate_4_0_key_loader.sv - serial key receive, CRC verify and start gating for calculate_4_0_obf
module calculate_4_0_key_loader
   import calc_lock_pkg::*;
(
   input  logic             ap_clk,
   input  logic             ap_rst,
   input  logic             key_load_start,
   input  logic             key_bit_in,
   input  logic             key_bit_valid,
   input  logic             ap_start_in,
   output logic             ap_start_out,
   output logic             key_busy,
   output logic             key_ready,
   output logic             key_error,
   output logic [KEY_W-1:0] locking_key
);

   key_ld_state_t    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [KEY_W-1:0] sr_q, sr_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic [CRC_W-1:0] rx_crc_q, rx_crc_d;
   logic [CRC_W-1:0] crc_acc;
   logic             crc_clr;
   logic             crc_en;

   crc8_serial u_crc (
      .clk_i (ap_clk),
      .rst_i (ap_rst),
      .clr_i (crc_clr),
      .en_i  (crc_en),
      .bit_i (key_bit_in),
      .crc_o (crc_acc)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sr_d     = sr_q;
      key_d    = key_q;
      rx_crc_d = rx_crc_q;
      crc_clr  = 1'b0;
      crc_en   = 1'b0;
      // A restart pre-empts everything, including a bit offered in the same cycle.
      if (key_load_start) begin
         state_d  = SHIFT_KEY;
         cnt_d    = '0;
         sr_d     = '0;
         key_d    = '0;
         rx_crc_d = '0;
         crc_clr  = 1'b1;
      end else begin
         case (state_q)
            SHIFT_KEY: begin
               if (key_bit_valid) begin
                  sr_d   = {sr_q[KEY_W-2:0], key_bit_in};
                  crc_en = 1'b1;
                  if (cnt_q == KEY_LAST) begin
                     cnt_d   = '0;
                     state_d = SHIFT_CRC;
                  end else begin
                     cnt_d = cnt_q + 9'd1;
                  end
               end
            end
            SHIFT_CRC: begin
               if (key_bit_valid) begin
                  rx_crc_d = {rx_crc_q[CRC_W-2:0], key_bit_in};
                  if (cnt_q == CRC_LAST) begin
                     cnt_d = '0;
                     if (rx_crc_d == crc_acc) begin
                        state_d = LOCKED;
                        key_d   = sr_q;
                     end else begin
                        state_d = ERROR;
                     end
                  end else begin
                     cnt_d = cnt_q + 9'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         sr_q     <= '0;
         key_q    <= '0;
         rx_crc_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sr_q     <= sr_d;
         key_q    <= key_d;
         rx_crc_q <= rx_crc_d;
      end
   end

   assign key_busy     = (state_q == SHIFT_KEY) || (state_q == SHIFT_CRC);
   assign key_ready    = (state_q == LOCKED);
   assign key_error    = (state_q == ERROR);
   assign locking_key  = key_q;
   assign ap_start_out = ap_start_in & key_ready;

endmodule

// File: tb/tb_calculate_4_0_key_loader.sv
// tb/tb_calculate_4_0_key_loader.sv - directed table-driven bench for the key loader
module tb_calculate_4_0_key_loader;

   logic         ap_clk = 1'b0;
   logic         ap_rst = 1'b1;
   logic         key_load_start = 1'b0;
   logic         key_bit_in = 1'b0;
   logic         key_bit_valid = 1'b0;
   logic         ap_start_in = 1'b0;
   logic         ap_start_out;
   logic         key_busy;
   logic         key_ready;
   logic         key_error;
   logic [254:0] locking_key;

   int checks = 0;
   int errors = 0;

   always #5 ap_clk = ~ap_clk;

   calculate_4_0_key_loader dut (
      .ap_clk         (ap_clk),
      .ap_rst         (ap_rst),
      .key_load_start (key_load_start),
      .key_bit_in     (key_bit_in),
      .key_bit_valid  (key_bit_valid),
      .ap_start_in    (ap_start_in),
      .ap_start_out   (ap_start_out),
      .key_busy       (key_busy),
      .key_ready      (key_ready),
      .key_error      (key_error),
      .locking_key    (locking_key)
   );

   typedef struct {
      string        name;
      logic [254:0] key;
      logic         use_model;
      logic [7:0]   crc;
      logic         gaps;
      logic         exp_ready;
      logic         exp_error;
      logic [254:0] exp_key;
   } vec_t;

   vec_t vecs[6];

   // Reference CRC by long division of key * x^8 modulo x^8 + x^2 + x + 1.
   function automatic logic [7:0] ref_crc(input logic [254:0] k);
      logic [8:0] r;
      r = '0;
      for (int i = 254; i >= -8; i--) begin
         r = {r[7:0], (i >= 0) ? k[i] : 1'b0};
         if (r[8]) r = r ^ 9'h107;
      end
      return r[7:0];
   endfunction

   task automatic chk(input string name, input logic [254:0] act, input logic [254:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      key_bit_valid = 1'b1;
      key_bit_in    = b;
      tick();
      key_bit_valid = 1'b0;
      key_bit_in    = ~b;
   endtask

   task automatic start_frame();
      key_load_start = 1'b1;
      tick();
      key_load_start = 1'b0;
      chk("busy_after_start", 255'(key_busy), 255'(1'b1));
      chk("start_gated", 255'(ap_start_out), 255'(1'b0));
   endtask

   task automatic send_frame(input logic [254:0] k, input logic [7:0] c, input logic gaps);
      for (int i = 254; i >= 0; i--) begin
         if (gaps && i[0]) tick();
         send_bit(k[i]);
      end
      for (int i = 7; i >= 1; i--) begin
         if (gaps && i[0]) tick();
         send_bit(c[i]);
      end
      chk("busy_before_last", 255'(key_busy), 255'(1'b1));
      chk("not_ready_before_last", 255'(key_ready), 255'(1'b0));
      send_bit(c[0]);
   endtask

   task automatic chk_idle(input string name);
      chk({name, "_busy"}, 255'(key_busy), 255'(1'b0));
      chk({name, "_ready"}, 255'(key_ready), 255'(1'b0));
      chk({name, "_error"}, 255'(key_error), 255'(1'b0));
      chk({name, "_key"}, locking_key, 255'(0));
      chk({name, "_start"}, 255'(ap_start_out), 255'(1'b0));
   endtask

   initial begin
      logic [254:0] pat;
      logic [254:0] one_hot;
      logic [7:0]   c;
      pat     = {85{3'b101}};
      one_hot = {1'b1, 254'b0};

      vecs[0] = '{"zero_good", 255'(0), 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 255'(0)};
      vecs[1] = '{"zero_bad",  255'(0), 1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 255'(0)};
      vecs[2] = '{"msb_gaps",  one_hot, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, one_hot};
      vecs[3] = '{"pattern",   pat,     1'b1, 8'h00, 1'b0, 1'b1, 1'b0, pat};
      vecs[4] = '{"pat_bad",   pat,     1'b1, 8'h80, 1'b1, 1'b0, 1'b1, 255'(0)};
      vecs[5] = '{"all_ones",  {255{1'b1}}, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, {255{1'b1}}};

      ap_start_in = 1'b1;
      tick();
      tick();
      ap_rst = 1'b0;
      chk_idle("reset");
      key_bit_valid = 1'b1;
      key_bit_in    = 1'b1;
      tick();
      key_bit_valid = 1'b0;
      chk_idle("idle_ignores_bits");

      for (int v = 0; v < 6; v++) begin
         c = vecs[v].use_model ? (ref_crc(vecs[v].key) ^ vecs[v].crc) : vecs[v].crc;
         ap_start_in = 1'b1;
         start_frame();
         send_frame(vecs[v].key, c, vecs[v].gaps);
         chk({vecs[v].name, "_ready"}, 255'(key_ready), 255'(vecs[v].exp_ready));
         chk({vecs[v].name, "_error"}, 255'(key_error), 255'(vecs[v].exp_error));
         chk({vecs[v].name, "_busy"}, 255'(key_busy), 255'(1'b0));
         chk({vecs[v].name, "_key"}, locking_key, vecs[v].exp_key);
         chk({vecs[v].name, "_start"}, 255'(ap_start_out), 255'(vecs[v].exp_ready));
         ap_start_in = 1'b0;
         #1;
         chk({vecs[v].name, "_start_low"}, 255'(ap_start_out), 255'(1'b0));
         for (int i = 0; i < 3; i++) send_bit(1'b1);
         chk({vecs[v].name, "_hold_key"}, locking_key, vecs[v].exp_key);
         chk({vecs[v].name, "_hold_ready"}, 255'(key_ready), 255'(vecs[v].exp_ready));
      end

      // Restart mid-frame with a coincident valid bit that must be dropped.
      start_frame();
      for (int i = 0; i < 100; i++) send_bit(1'b1);
      key_load_start = 1'b1;
      key_bit_valid  = 1'b1;
      key_bit_in     = 1'b1;
      tick();
      key_load_start = 1'b0;
      key_bit_valid  = 1'b0;
      chk("restart_busy", 255'(key_busy), 255'(1'b1));
      send_frame(255'(0), 8'h00, 1'b0);
      chk("restart_ready", 255'(key_ready), 255'(1'b1));
      chk("restart_error", 255'(key_error), 255'(1'b0));
      chk("restart_key", locking_key, 255'(0));

      // Reset mid-frame, then a good frame must still load.
      ap_start_in = 1'b1;
      start_frame();
      for (int i = 0; i < 200; i++) send_bit(pat[254 - i]);
      ap_rst = 1'b1;
      tick();
      chk_idle("mid_reset");
      ap_rst = 1'b0;
      tick();
      chk_idle("after_reset");
      start_frame();
      send_frame(pat, ref_crc(pat), 1'b0);
      chk("post_reset_ready", 255'(key_ready), 255'(1'b1));
      chk("post_reset_key", locking_key, pat);
      chk("post_reset_start", 255'(ap_start_out), 255'(1'b1));

      // A new start pulse must drop the key and the start gate on the next cycle.
      start_frame();
      chk("restart_clears_key", locking_key, 255'(0));
      chk("restart_clears_ready", 255'(key_ready), 255'(1'b0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
